// File: rtl/rs_int_issue_if.sv
// Dispatch, CDB and issue-side signal bundle for rs_int_issue.
// slave is the station's view; master is the surrounding pipeline's view.
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS [4:0]
`endif
`ifndef OPGEN_BUS
`define OPGEN_BUS [3:0]
`endif
`ifndef SHAMT_BUS
`define SHAMT_BUS [4:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif

interface rs_int_issue_if;
  logic               alloc_valid;
  logic               alloc_ready;
  logic `ROB_ADDR_BUS alloc_rob_addr;
  logic `OPGEN_BUS    alloc_opgen;
  logic `SHAMT_BUS    alloc_shamt;
  logic               alloc_is_ref_1;
  logic               alloc_is_ref_2;
  logic `DATA_BUS     alloc_data_1;
  logic `DATA_BUS     alloc_data_2;
  logic               cdb_en;
  logic `DATA_BUS     cdb_ref_id;
  logic `DATA_BUS     cdb_data;
  logic               issue_valid;
  logic               issue_ready;
  logic `ROB_ADDR_BUS issue_rob_addr;
  logic `OPGEN_BUS    issue_opgen;
  logic `SHAMT_BUS    issue_shamt;
  logic `DATA_BUS     issue_data_1;
  logic `DATA_BUS     issue_data_2;

  modport master (
    output alloc_valid, alloc_rob_addr, alloc_opgen, alloc_shamt, alloc_is_ref_1,
           alloc_is_ref_2, alloc_data_1, alloc_data_2, cdb_en, cdb_ref_id, cdb_data,
           issue_ready,
    input  alloc_ready, issue_valid, issue_rob_addr, issue_opgen, issue_shamt,
           issue_data_1, issue_data_2
  );

  modport slave (
    input  alloc_valid, alloc_rob_addr, alloc_opgen, alloc_shamt, alloc_is_ref_1,
           alloc_is_ref_2, alloc_data_1, alloc_data_2, cdb_en, cdb_ref_id, cdb_data,
           issue_ready,
    output alloc_ready, issue_valid, issue_rob_addr, issue_opgen, issue_shamt,
           issue_data_1, issue_data_2
  );
endinterface

// File: rtl/rs_int_issue.sv
// Integer reservation station with CDB wakeup, age-matrix oldest-ready select and a registered
// issue slot. Optional macro RS_ALLOC_WAKEUP_EN captures a CDB result on the allocating op.
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS [4:0]
`endif
`ifndef OPGEN_BUS
`define OPGEN_BUS [3:0]
`endif
`ifndef SHAMT_BUS
`define SHAMT_BUS [4:0]
`endif
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif

module rs_int_issue #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rs_int_issue_if.slave    bus,
  output logic [IDX_W:0]   free_count
);

  logic [ENTRIES-1:0] valid_q, ref1_q, ref2_q;
  logic `ROB_ADDR_BUS rob_q   [ENTRIES];
  logic `OPGEN_BUS    opgen_q [ENTRIES];
  logic `SHAMT_BUS    shamt_q [ENTRIES];
  logic `DATA_BUS     data1_q [ENTRIES];
  logic `DATA_BUS     data2_q [ENTRIES];
  // older_q[i][j] set means entry i was allocated before entry j
  logic [ENTRIES-1:0] older_q [ENTRIES];

  logic [IDX_W:0]     free_q;
  logic               iss_valid_q;
  logic `ROB_ADDR_BUS iss_rob_q;
  logic `OPGEN_BUS    iss_opgen_q;
  logic `SHAMT_BUS    iss_shamt_q;
  logic `DATA_BUS     iss_data1_q, iss_data2_q;

  logic [ENTRIES-1:0] ready, blocked;
  logic [IDX_W-1:0]   sel_idx, alloc_idx;
  logic               any_ready, slot_free, sel_fire, alloc_ready, alloc_fire;
  logic               a_hit1, a_hit2;

  assign ready     = valid_q & ~ref1_q & ~ref2_q;
  assign any_ready = |ready;
  assign slot_free = ~iss_valid_q | bus.issue_ready;
  assign sel_fire  = slot_free & any_ready & ~flush;

  // An entry is selectable only if no older entry is also ready.
  always_comb begin
    blocked = '0;
    sel_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i] && !blocked[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef RS_ALLOC_WAKEUP_EN
  assign a_hit1 = bus.cdb_en & bus.alloc_is_ref_1 & (bus.alloc_data_1 == bus.cdb_ref_id);
  assign a_hit2 = bus.cdb_en & bus.alloc_is_ref_2 & (bus.alloc_data_2 == bus.cdb_ref_id);
  assign alloc_ready = (free_q != '0) & ~flush;
`else
  assign a_hit1 = 1'b0;
  assign a_hit2 = 1'b0;
  // Never allocate during a broadcast, so no in-flight result can be missed.
  assign alloc_ready = (free_q != '0) & ~flush & ~bus.cdb_en;
`endif

  assign alloc_fire = bus.alloc_valid & alloc_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ref1_q  <= '0;
      ref2_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        rob_q[i]   <= '0;
        opgen_q[i] <= '0;
        shamt_q[i] <= '0;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.cdb_en && valid_q[i] && ref1_q[i] && data1_q[i] == bus.cdb_ref_id) begin
          data1_q[i] <= bus.cdb_data;
          ref1_q[i]  <= 1'b0;
        end
        if (bus.cdb_en && valid_q[i] && ref2_q[i] && data2_q[i] == bus.cdb_ref_id) begin
          data2_q[i] <= bus.cdb_data;
          ref2_q[i]  <= 1'b0;
        end
      end
      if (sel_fire) valid_q[sel_idx] <= 1'b0;
      if (alloc_fire) begin
        valid_q[alloc_idx] <= 1'b1;
        rob_q[alloc_idx]   <= bus.alloc_rob_addr;
        opgen_q[alloc_idx] <= bus.alloc_opgen;
        shamt_q[alloc_idx] <= bus.alloc_shamt;
        ref1_q[alloc_idx]  <= bus.alloc_is_ref_1 & ~a_hit1;
        ref2_q[alloc_idx]  <= bus.alloc_is_ref_2 & ~a_hit2;
        data1_q[alloc_idx] <= a_hit1 ? bus.cdb_data : bus.alloc_data_1;
        data2_q[alloc_idx] <= a_hit2 ? bus.cdb_data : bus.alloc_data_2;
        for (int j = 0; j < ENTRIES; j++) older_q[j][alloc_idx] <= valid_q[j];
        older_q[alloc_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_q <= 1'b0;
      iss_rob_q   <= '0;
      iss_opgen_q <= '0;
      iss_shamt_q <= '0;
      iss_data1_q <= '0;
      iss_data2_q <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (sel_fire) begin
      iss_valid_q <= 1'b1;
      iss_rob_q   <= rob_q[sel_idx];
      iss_opgen_q <= opgen_q[sel_idx];
      iss_shamt_q <= shamt_q[sel_idx];
      iss_data1_q <= data1_q[sel_idx];
      iss_data2_q <= data2_q[sel_idx];
    end else if (bus.issue_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= (IDX_W + 1)'(ENTRIES);
    end else if (flush) begin
      free_q <= (IDX_W + 1)'(ENTRIES);
    end else begin
      free_q <= free_q + {{IDX_W{1'b0}}, sel_fire} - {{IDX_W{1'b0}}, alloc_fire};
    end
  end

  assign free_count         = free_q;
  assign bus.alloc_ready    = alloc_ready;
  assign bus.issue_valid    = iss_valid_q;
  assign bus.issue_rob_addr = iss_rob_q;
  assign bus.issue_opgen    = iss_opgen_q;
  assign bus.issue_shamt    = iss_shamt_q;
  assign bus.issue_data_1   = iss_data1_q;
  assign bus.issue_data_2   = iss_data2_q;

endmodule

// File: doc/rs_int_issue.md
Name: rs_int_issue

Overview:
- N-entry integer reservation station with an issue stage.
- Accepts decoded integer ops from dispatch and holds them until both operands are resolved. Snoops the CDB for wakeup.
- Selects the oldest ready entry into a registered issue slot that feeds the integer ALU over a valid/ready handshake.
- Sits between dispatch/rename (upstream) and the integer ALU (downstream).

Parameters:
- ENTRIES, 4, number of station entries; power of two, 2..16.
- IDX_W, 2, entry index width, equal to log2(ENTRIES).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- flush  input  1  synchronous kill of all entries and of the issue slot.
- alloc_valid  input  1  dispatch presents an op.
- alloc_ready  output  1  station can accept an op this cycle.
- alloc_rob_addr  input  `ROB_ADDR_BUS  destination ROB slot.
- alloc_opgen  input  `OPGEN_BUS  ALU operation.
- alloc_shamt  input  `SHAMT_BUS  shift amount.
- alloc_is_ref_1, alloc_is_ref_2  input  1 each  operand holds a ROB ref id, not a value.
- alloc_data_1, alloc_data_2  input  `DATA_BUS each  operand value or ref id.
- cdb_en  input  1  CDB broadcast valid.
- cdb_ref_id  input  `DATA_BUS  producing ref id.
- cdb_data  input  `DATA_BUS  broadcast result.
- issue_valid  output  1  issue slot holds an op.
- issue_ready  input  1  ALU accepts the op.
- issue_rob_addr, issue_opgen, issue_shamt, issue_data_1, issue_data_2  output  field widths as for alloc  registered issue slot contents.
- free_count  output  IDX_W+1  number of empty entries.

Behaviour:
- Reset (rst=1, asynchronous):
  - All entries invalid; age state cleared.
  - issue_valid=0; all issue_* data outputs 0.
  - free_count=ENTRIES; alloc_ready=1.
- Entry state: valid, rob_addr, opgen, shamt, is_ref_1/2, data_1/2.
  - Entry ready = valid & !is_ref_1 & !is_ref_2.
- Allocation:
  - Fires when alloc_valid & alloc_ready.
  - Writes the lowest-index invalid entry.
  - alloc_ready = (free_count != 0) & !flush.
- Wakeup:
  - When cdb_en=1, every valid entry with is_ref_k=1 and data_k==cdb_ref_id takes data_k<=cdb_data and is_ref_k<=0.
  - Both operands may wake in the same cycle.
  - Wakeup and allocation are independent; both happen in the same cycle.
- Age: an age matrix tracks allocation order.
  - The newly allocated entry is younger than all currently valid entries.
- Issue slot (registered):
  - slot_free = !issue_valid | issue_ready.
  - If slot_free and at least one entry is ready at the start of the cycle:
    - load the oldest ready entry into the slot;
    - invalidate that entry;
    - set issue_valid=1.
  - Else if issue_ready: issue_valid<=0.
  - While issue_valid & !issue_ready, slot contents hold stable.
- Latency:
  - An op allocated with both operands resolved at edge t is issued (issue_valid=1) at edge t+1.
  - A CDB wakeup at edge t makes the entry selectable at edge t+1.
- Throughput: one issue per cycle with the ALU continuously ready.
- free_count: registered. Next value = current − alloc_fire + select_fire.
  - An entry freed by selection is not reusable in the same cycle, because alloc_ready uses the registered count.
- Full: free_count=0 gives alloc_ready=0. alloc_valid is ignored, and no state changes from it.
- Flush: has priority over alloc, wakeup and select.
  - Next cycle: all entries invalid, issue_valid=0, free_count=ENTRIES.
- Reset mid-operation: immediate return to the reset state regardless of pending handshakes.

Optional Feature:
- Macro: RS_ALLOC_WAKEUP_EN.
- Defined: an allocating operand with alloc_is_ref_k=1 and alloc_data_k==cdb_ref_id while cdb_en=1 is written resolved (is_ref_k=0, data_k=cdb_data).
- Undefined: alloc_ready is additionally gated by !cdb_en, so allocation never coincides with a broadcast and no broadcast can be missed.

Test Plan:
- Reset then alloc {rob=3, opgen=ADD, data_1=5, data_2=7, refs=0} → next edge issue_valid=1, issue_rob_addr=3, issue_data_1=5, issue_data_2=7; free_count returns to 4.
- Alloc rob=1 with is_ref_1=1, data_1=0x9. Then cdb_en, ref_id=0x9, data=0x55 → one cycle later issue_valid=1, issue_data_1=0x55.
- Fill 4 entries with issue_ready=0 and all operands waiting → alloc_ready=0; a 5th alloc_valid is ignored. Release via CDB → entries issue oldest first: rob 0,1,2,3.
- Alloc rob=A (waiting), then rob=B (ready), then wake A. Hold issue_ready=0 → B is issued first and held stable. Raise issue_ready → A follows the next cycle.
- Same-cycle alloc with is_ref_1=1, data_1=0x4 and cdb_en ref 0x4, data 0x77:
  - with RS_ALLOC_WAKEUP_EN → issued next cycle with data_1=0x77;
  - without → alloc_ready=0 that cycle.
- Three valid entries with issue_valid=1, then flush=1 → next cycle issue_valid=0, free_count=4, and no stale op issues afterward.
